voice_mix_scheduler: RTL and testbench

Time-multiplexes the shared oscillator pipeline across all voices once per audio sample period and accumulates the returned samples into one mixed sample. It is started by the sample-rate tick derived from the I2S LR clock. It hands the finished sample to the I2S serializer over a valid/ready handshake. It sits between the oscillator bank and the DAC output stage in `top`.

---
 rtl/voice_mix_scheduler_if.sv | 26 ++
 rtl/voice_mix_scheduler.sv | 144 ++++++++++++++
 tb/tb_voice_mix_scheduler.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_mix_scheduler_if.sv
// Oscillator-pipeline and mixed-sample handshake bundle for voice_mix_scheduler.
// master = scheduler side, slave = oscillator bank / I2S stage side.
interface voice_mix_scheduler_if #(
  parameter int N_VOICES     = 8,
  parameter int SAMPLE_WIDTH = 24
);
  localparam int VW = $clog2(N_VOICES);

  logic                           osc_issue;
  logic        [VW-1:0]           osc_voice;
  logic                           osc_valid;
  logic signed [SAMPLE_WIDTH-1:0] osc_sample;
  logic signed [SAMPLE_WIDTH-1:0] mix_data;
  logic                           mix_valid;
  logic                           mix_ready;

  modport master (
    output osc_issue, osc_voice, mix_data, mix_valid,
    input  osc_valid, osc_sample, mix_ready
  );

  modport slave (
    input  osc_issue, osc_voice, mix_data, mix_valid,
    output osc_valid, osc_sample, mix_ready
  );
endinterface

// File: rtl/voice_mix_scheduler.sv
// Per-sample-period voice scheduler and mixer: issues every voice once, sums results, hands off.
// Optional build macro MIX_SATURATE_EN clamps the mix to the signed sample range instead of wrapping.
module voice_mix_scheduler #(
  parameter int N_VOICES     = 8,
  parameter int SAMPLE_WIDTH = 24,
  parameter int ACC_WIDTH    = SAMPLE_WIDTH + $clog2(N_VOICES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick_i,
  input  logic [N_VOICES-1:0] voice_enable_i,
  output logic                busy_o,
  output logic                overrun_o,
  voice_mix_scheduler_if.master bus
);
  localparam int VW = $clog2(N_VOICES);
  localparam int OW = $clog2(N_VOICES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  state_t                          state_q;
  logic        [VW-1:0]            voice_q;
  logic                            issue_q;
  logic        [OW-1:0]            outstanding_q, outstanding_d;
  logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic signed [SAMPLE_WIDTH-1:0]  mix_q, mix_d;
  logic                            mix_valid_q;
  logic                            busy_q;
  logic                            overrun_q;
  logic                            active_s;
  logic                            last_voice_s;
  logic        [VW-1:0]            next_voice_s;

`ifdef MIX_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  function automatic logic signed [SAMPLE_WIDTH-1:0] reduce_acc(input logic signed [ACC_WIDTH-1:0] a);
    if (a > SAT_MAX) begin
      return SAT_MAX[SAMPLE_WIDTH-1:0];
    end else if (a < SAT_MIN) begin
      return SAT_MIN[SAMPLE_WIDTH-1:0];
    end else begin
      return a[SAMPLE_WIDTH-1:0];
    end
  endfunction
`else
  function automatic logic signed [SAMPLE_WIDTH-1:0] reduce_acc(input logic signed [ACC_WIDTH-1:0] a);
    return a[SAMPLE_WIDTH-1:0];
  endfunction
`endif

  assign active_s     = (state_q == ISSUE) || (state_q == DRAIN);
  assign last_voice_s = (voice_q == VW'(N_VOICES - 1));
  assign next_voice_s = voice_q + VW'(1);
  assign mix_d        = reduce_acc(acc_q);

  // Results only count while a period is in flight; stragglers in IDLE/OUTPUT are dropped.
  always_comb begin
    outstanding_d = outstanding_q;
    acc_d         = acc_q;
    if (active_s) begin
      outstanding_d = outstanding_q + OW'(issue_q) - OW'(bus.osc_valid);
      if (bus.osc_valid) begin
        acc_d = acc_q + ACC_WIDTH'(bus.osc_sample);
      end else begin
        acc_d = acc_q;
      end
    end else begin
      outstanding_d = outstanding_q;
      acc_d         = acc_q;
    end
  end

  // Scheduler FSM; issue strobe/voice are computed one cycle ahead so they appear registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      voice_q       <= '0;
      issue_q       <= 1'b0;
      outstanding_q <= '0;
      acc_q         <= '0;
      mix_q         <= '0;
      mix_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      overrun_q     <= sample_tick_i && (state_q != IDLE);
      outstanding_q <= outstanding_d;
      acc_q         <= acc_d;
      case (state_q)
        IDLE: begin
          if (sample_tick_i) begin
            state_q       <= ISSUE;
            busy_q        <= 1'b1;
            voice_q       <= '0;
            issue_q       <= voice_enable_i[0];
            outstanding_q <= '0;
            acc_q         <= '0;
          end
        end
        ISSUE: begin
          if (last_voice_s) begin
            state_q <= DRAIN;
            voice_q <= '0;
            issue_q <= 1'b0;
          end else begin
            voice_q <= next_voice_s;
            issue_q <= voice_enable_i[next_voice_s];
          end
        end
        DRAIN: begin
          if ((outstanding_q == '0) && !bus.osc_valid) begin
            state_q     <= OUTPUT;
            mix_q       <= mix_d;
            mix_valid_q <= 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.mix_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            mix_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          issue_q     <= 1'b0;
          mix_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.osc_issue = issue_q;
  assign bus.osc_voice = voice_q;
  assign bus.mix_data  = mix_q;
  assign bus.mix_valid = mix_valid_q;
  assign busy_o        = busy_q;
  assign overrun_o     = overrun_q;
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Directed bench for voice_mix_scheduler: N_VOICES=4, 24-bit samples, oscillator latency 3.
module tb_voice_mix_scheduler;
  localparam int NV = 4;
  localparam int SW = 24;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_tick;
  logic [NV-1:0] voice_enable;
  logic          busy;
  logic          overrun;

  voice_mix_scheduler_if #(.N_VOICES(NV), .SAMPLE_WIDTH(SW)) bus ();

  voice_mix_scheduler #(.N_VOICES(NV), .SAMPLE_WIDTH(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_tick_i  (sample_tick),
    .voice_enable_i (voice_enable),
    .busy_o         (busy),
    .overrun_o      (overrun),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int cycle  = 0;
  int n_issue;
  int mv_cyc;
  int iss_cyc [0:NV-1];
  int iss_vox [0:NV-1];
  logic [SW-1:0] mv_data;
  logic [SW-1:0] vval [0:NV-1];
  logic          pv   [0:L];
  logic [1:0]    pvx  [0:L];
  logic [SW-1:0] held;
  logic [SW-1:0] exp_pos;
  logic [SW-1:0] exp_neg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample DUT 1ns after the edge, advance the oscillator model and record events.
  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    for (int s = L; s > 0; s--) begin
      pv[s]  = pv[s-1];
      pvx[s] = pvx[s-1];
    end
    pv[0]  = bus.osc_issue;
    pvx[0] = bus.osc_voice;
    bus.osc_valid  = pv[L];
    bus.osc_sample = pv[L] ? vval[pvx[L]] : '0;
    if (bus.osc_issue) begin
      if (n_issue < NV) begin
        iss_cyc[n_issue] = cycle;
        iss_vox[n_issue] = int'(bus.osc_voice);
      end
      n_issue++;
    end
    if (bus.mix_valid && mv_cyc < 0) begin
      mv_cyc  = cycle;
      mv_data = bus.mix_data;
    end
  endtask

  task automatic start_tick(input logic [NV-1:0] en);
    voice_enable = en;
    sample_tick  = 1'b1;
    cycle   = 0;
    n_issue = 0;
    mv_cyc  = -1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    while (mv_cyc < 0 && cycle < 60) cyc();
    chk({tag, "_valid_seen"}, 32'(mv_cyc >= 0), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    sample_tick = 1'b0;
    voice_enable = '0;
    bus.osc_valid = 1'b0;
    bus.osc_sample = '0;
    bus.mix_ready = 1'b1;
    n_issue = 0;
    mv_cyc = -1;
    mv_data = '0;
    for (int s = 0; s <= L; s++) begin
      pv[s] = 1'b0;
      pvx[s] = 2'd0;
    end
`ifdef MIX_SATURATE_EN
    exp_pos = 24'h7FFFFF;
    exp_neg = 24'h800000;
`else
    exp_pos = 24'h000000;
    exp_neg = 24'h000000;
`endif

    // Reset state
    repeat (3) cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_issue", 32'(bus.osc_issue), 32'd0);
    chk("rst_voice", 32'(bus.osc_voice), 32'd0);
    chk("rst_mix_valid", 32'(bus.mix_valid), 32'd0);
    chk("rst_mix_data", 32'(bus.mix_data), 32'd0);
    rst = 1'b0;
    repeat (2) cyc();

    // Basic mix
    for (int k = 0; k < NV; k++) vval[k] = 24'h001000;
    start_tick(4'b1111);
    wait_valid("basic");
    chk("basic_n_issue", 32'(n_issue), 32'd4);
    for (int k = 0; k < NV; k++) begin
      chk("basic_issue_cycle", 32'(iss_cyc[k]), 32'(k + 1));
      chk("basic_issue_voice", 32'(iss_vox[k]), 32'(k));
    end
    chk("basic_valid_cycle", 32'(mv_cyc), 32'd9);
    chk("basic_data", 32'(mv_data), 32'h004000);
    cyc();
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_idle_valid", 32'(bus.mix_valid), 32'd0);
    repeat (3) cyc();

    // Positive overflow
    for (int k = 0; k < NV; k++) vval[k] = 24'h400000;
    start_tick(4'b1111);
    wait_valid("sat_pos");
    chk("sat_pos_data", 32'(mv_data), 32'(exp_pos));
    repeat (4) cyc();

    // Negative overflow
    for (int k = 0; k < NV; k++) vval[k] = 24'hC00000;
    start_tick(4'b1111);
    wait_valid("sat_neg");
    chk("sat_neg_data", 32'(mv_data), 32'(exp_neg));
    repeat (4) cyc();

    // Sparse enables
    vval[0] = 24'd100;
    vval[1] = 24'd999;
    vval[2] = 24'hFFFFE2;
    vval[3] = 24'd999;
    start_tick(4'b0101);
    wait_valid("sparse");
    chk("sparse_n_issue", 32'(n_issue), 32'd2);
    chk("sparse_cycle0", 32'(iss_cyc[0]), 32'd1);
    chk("sparse_voice0", 32'(iss_vox[0]), 32'd0);
    chk("sparse_cycle1", 32'(iss_cyc[1]), 32'd3);
    chk("sparse_voice1", 32'(iss_vox[1]), 32'd2);
    chk("sparse_data", 32'(mv_data), 32'd70);
    repeat (4) cyc();

    // Back-pressure with a dropped tick, then a tick on the handshake cycle
    vval[0] = 24'd1;
    vval[1] = 24'd2;
    vval[2] = 24'd3;
    vval[3] = 24'd4;
    bus.mix_ready = 1'b0;
    start_tick(4'b1111);
    wait_valid("bp");
    chk("bp_data", 32'(mv_data), 32'd10);
    held = mv_data;
    for (int j = 0; j < 20; j++) begin
      sample_tick = (j == 5);
      cyc();
      sample_tick = 1'b0;
      chk("bp_data_stable", 32'(bus.mix_data), 32'(held));
      chk("bp_valid_held", 32'(bus.mix_valid), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_overrun", 32'(overrun), 32'(j == 5));
    end
    chk("bp_no_extra_issue", 32'(n_issue), 32'd4);
    bus.mix_ready = 1'b1;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    chk("hs_valid_low", 32'(bus.mix_valid), 32'd0);
    chk("hs_busy_low", 32'(busy), 32'd0);
    chk("hs_overrun", 32'(overrun), 32'd1);
    repeat (3) cyc();
    chk("hs_tick_dropped_busy", 32'(busy), 32'd0);
    chk("hs_tick_dropped_issue", 32'(n_issue), 32'd4);
    chk("hs_overrun_single", 32'(overrun), 32'd0);

    // Empty mix
    start_tick(4'b0000);
    wait_valid("empty");
    chk("empty_n_issue", 32'(n_issue), 32'd0);
    chk("empty_valid_cycle", 32'(mv_cyc), 32'd6);
    chk("empty_data", 32'(mv_data), 32'd0);
    repeat (4) cyc();

    // Reset in the middle of ISSUE, stragglers afterwards
    for (int k = 0; k < NV; k++) vval[k] = 24'd5;
    start_tick(4'b1111);
    cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_issue", 32'(bus.osc_issue), 32'd0);
    chk("mid_rst_voice", 32'(bus.osc_voice), 32'd0);
    chk("mid_rst_valid", 32'(bus.mix_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.mix_data), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(bus.mix_valid), 32'd0);
    for (int k = 0; k < NV; k++) vval[k] = 24'd7;
    start_tick(4'b1111);
    wait_valid("fresh");
    chk("fresh_first_voice", 32'(iss_vox[0]), 32'd0);
    chk("fresh_first_cycle", 32'(iss_cyc[0]), 32'd1);
    chk("fresh_n_issue", 32'(n_issue), 32'd4);
    chk("fresh_valid_cycle", 32'(mv_cyc), 32'd9);
    chk("fresh_data", 32'(mv_data), 32'd28);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
